// File: rtl/ldtu_ofifo_pkg.sv
// Shared types and constants for the LDTU output FIFO sequencing logic.
// Optional feature macro used elsewhere: LDTU_OFIFO_CTRL_AUTOSYNCH_EN.
package ldtu_ofifo_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SYNCH = 2'd2
  } ofifo_state_e;

  localparam int READ_DIV_DEF     = 4;
  localparam int FIFO_DEPTH_DEF   = 16;
  localparam int FLUSH_CYCLES_DEF = 4;

  // Downstream words the serializer sees when the FIFO is empty or just flushed
  localparam logic [31:0] IDLE_PATTERN = 32'hEAAA_AAAA;
  localparam logic [31:0] FLUSH_MARKER = 32'hE5E5_E5E5;

endpackage

// File: rtl/ldtu_ofifo_occ_cnt.sv
// Output FIFO occupancy tracker: saturating word count, near-full flag and
// sticky overflow flag.
module ldtu_ofifo_occ_cnt #(
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr_occ,
  input  logic             clr_ovf,
  output logic [PTR_W-1:0] occupancy,
  output logic             near_full,
  output logic             overflow
);

  localparam logic [PTR_W-1:0] OCC_FULL = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] OCC_NF   = PTR_W'(FIFO_DEPTH - 2);

  logic rd_eff;
  logic full;

  // A read strobe against an empty FIFO only refreshes the idle pattern
  assign rd_eff = rd_en && (occupancy != '0);
  assign full   = (occupancy == OCC_FULL);

  always_ff @(posedge CLK) begin
    if (reset) begin
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (clr_occ) begin
        occupancy <= '0;
      end else if (wr_en && !rd_eff) begin
        if (!full) occupancy <= occupancy + 1'b1;
      end else if (rd_eff && !wr_en) begin
        occupancy <= occupancy - 1'b1;
      end

      if (clr_ovf) begin
        overflow <= 1'b0;
      end else if (!clr_occ && wr_en && !rd_eff && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign near_full = (occupancy >= OCC_NF);

endmodule

// File: rtl/ldtu_ofifo_ctrl.sv
// Output FIFO sequencing controller: slot-cadence read strobe, timed flush and
// synch sequences, occupancy status. Optional macro LDTU_OFIFO_CTRL_AUTOSYNCH_EN.
//
// state    | meaning
// ST_RUN   | read strobe at every slot end, writes counted
// ST_FLUSH | flush held low for FLUSH_CYCLES cycles
// ST_SYNCH | synch held high until the N-th slot end after acceptance
module ldtu_ofifo_ctrl
  import ldtu_ofifo_pkg::*;
#(
  parameter int READ_DIV     = READ_DIV_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int PTR_W        = 5,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int SYNCH_LEN_W  = 4
`ifdef LDTU_OFIFO_CTRL_AUTOSYNCH_EN
  ,
  parameter int AUTOSYNCH_THR = 64
`endif
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   write_signal,
  input  logic                   flush_req,
  input  logic                   synch_req,
  input  logic [SYNCH_LEN_W-1:0] synch_len,
  output logic                   read_signal,
  output logic                   flush,
  output logic                   synch,
  output logic                   busy,
  output logic [PTR_W-1:0]       occupancy,
  output logic                   near_full,
  output logic                   overflow
);

  localparam int PH_W = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(READ_DIV - 1);

  ofifo_state_e           state, state_nxt;
  logic [PH_W-1:0]        phase, phase_nxt;
  logic [FC_W-1:0]        flush_cnt, flush_cnt_nxt;
  logic [SYNCH_LEN_W-1:0] synch_left, synch_left_nxt;
  logic                   slot_end;
  logic                   occ_clr, ovf_clr;
  logic                   auto_req;

`ifdef LDTU_OFIFO_CTRL_AUTOSYNCH_EN
  localparam int AS_W = $clog2(AUTOSYNCH_THR + 1);
  localparam logic [AS_W-1:0] AS_THR = AS_W'(AUTOSYNCH_THR);
  logic [AS_W-1:0] auto_cnt;

  assign auto_req = (state == ST_RUN) && (auto_cnt == AS_THR);

  // Counts consecutive empty slot ends in RUN; any synch or flush restarts it
  always_ff @(posedge CLK) begin
    if (reset) begin
      auto_cnt <= '0;
    end else if (state_nxt != ST_RUN) begin
      auto_cnt <= '0;
    end else if (slot_end) begin
      if (occupancy != '0)          auto_cnt <= '0;
      else if (auto_cnt != AS_THR)  auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  assign auto_req = 1'b0;
`endif

  assign slot_end  = (phase == PH_LAST);
  assign phase_nxt = slot_end ? '0 : phase + 1'b1;

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    synch_left_nxt = synch_left;
    occ_clr        = 1'b0;
    ovf_clr        = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (flush_req) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
          occ_clr       = 1'b1;
          ovf_clr       = 1'b1;
        end else if (synch_req || auto_req) begin
          state_nxt      = ST_SYNCH;
          synch_left_nxt = (!synch_req || synch_len == '0) ? SYNCH_LEN_W'(1) : synch_len;
          occ_clr        = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) state_nxt = ST_RUN;
        else                 flush_cnt_nxt = flush_cnt - 1'b1;
      end
      ST_SYNCH: begin
        if (flush_req) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
          occ_clr       = 1'b1;
          ovf_clr       = 1'b1;
        end else if (slot_end) begin
          if (synch_left == SYNCH_LEN_W'(1)) state_nxt = ST_RUN;
          else                               synch_left_nxt = synch_left - 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= ST_RUN;
      phase       <= '0;
      flush_cnt   <= '0;
      synch_left  <= '0;
      read_signal <= 1'b0;
      flush       <= 1'b1;
      synch       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      flush_cnt   <= flush_cnt_nxt;
      synch_left  <= synch_left_nxt;
      read_signal <= (state_nxt == ST_RUN) && (phase_nxt == PH_LAST);
      flush       <= (state_nxt != ST_FLUSH);
      synch       <= (state_nxt == ST_SYNCH);
      busy        <= (state_nxt != ST_RUN);
    end
  end

  ldtu_ofifo_occ_cnt #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_W     (PTR_W)
  ) u_occ_cnt (
    .CLK      (CLK),
    .reset    (reset),
    .wr_en    (write_signal && (state == ST_RUN)),
    .rd_en    (read_signal),
    .clr_occ  (occ_clr),
    .clr_ovf  (ovf_clr),
    .occupancy(occupancy),
    .near_full(near_full),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_ldtu_ofifo_ctrl.sv
// Bench for ldtu_ofifo_ctrl: directed sequences with literal expectations plus
// randomized traffic checked every cycle against a time-window reference model.
module tb_ldtu_ofifo_ctrl;

  localparam int RD    = 4;
  localparam int DEPTH = 16;
  localparam int FCYC  = 4;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       write_signal = 1'b0;
  logic       flush_req = 1'b0;
  logic       synch_req = 1'b0;
  logic [3:0] synch_len = 4'd0;
  logic       read_signal, flush, synch, busy, near_full, overflow;
  logic [4:0] occupancy;

  int total = 0;
  int bad = 0;

  ldtu_ofifo_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .write_signal(write_signal),
    .flush_req   (flush_req),
    .synch_req   (synch_req),
    .synch_len   (synch_len),
    .read_signal (read_signal),
    .flush       (flush),
    .synch       (synch),
    .busy        (busy),
    .occupancy   (occupancy),
    .near_full   (near_full),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: mode 0 run, 1 flushing window, 2 synch window
  int m_cyc = 0;
  int m_mode = 0;
  int m_flush_end = 0;
  int m_synch_end = 0;
  int m_occ = 0;
  bit m_ovf = 1'b0;

  function automatic bit exp_read();
    return (m_mode == 0) && ((m_cyc % RD) == RD - 1);
  endfunction

  function automatic int next_slot_end(input int a);
    return a + 1 + ((RD - 1) - ((a + 1) % RD));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_advance(input bit w, input bit fr, input bit sr, input int len, input bit rst);
    bit r;
    int nc;
    int n;
    r = exp_read() && (m_occ > 0);
    if (rst) begin
      m_cyc = 0; m_mode = 0; m_occ = 0; m_ovf = 1'b0;
      return;
    end
    nc = m_cyc + 1;
    if ((m_mode == 0 || m_mode == 2) && fr) begin
      m_mode = 1; m_flush_end = m_cyc + FCYC; m_occ = 0; m_ovf = 1'b0;
    end else if (m_mode == 0 && sr) begin
      n = (len == 0) ? 1 : len;
      m_mode = 2; m_synch_end = next_slot_end(m_cyc) + (n - 1) * RD; m_occ = 0;
    end else if (m_mode == 0) begin
      if (w && !r) begin
        if (m_occ == DEPTH) m_ovf = 1'b1;
        else m_occ++;
      end else if (r && !w) begin
        m_occ--;
      end
    end else if (m_mode == 1 && nc > m_flush_end) begin
      m_mode = 0;
    end else if (m_mode == 2 && nc > m_synch_end) begin
      m_mode = 0;
    end
    m_cyc = nc;
  endtask

  task automatic compare_all();
    check("read_signal", int'(read_signal), int'(exp_read()));
    check("flush", int'(flush), (m_mode == 1) ? 0 : 1);
    check("synch", int'(synch), (m_mode == 2) ? 1 : 0);
    check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    check("occupancy", int'(occupancy), m_occ);
    check("near_full", int'(near_full), (m_occ >= DEPTH - 2) ? 1 : 0);
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  // Drive one cycle of inputs, then land mid-cycle after the edge and compare
  task automatic step(input bit w, input bit fr, input bit sr, input int len, input bit rst);
    write_signal = w; flush_req = fr; synch_req = sr; synch_len = 4'(len); reset = rst;
    @(negedge CLK);
    model_advance(w, fr, sr, len, rst);
    compare_all();
  endtask

  initial begin
    logic [15:0] rd_mask;
    int cnt_a;
    int cnt_b;

    @(negedge CLK);
    repeat (3) step(0, 0, 0, 0, 1);

    // 1: idle cadence after reset release
    rd_mask = '0;
    rd_mask[0] = read_signal;
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 0, 0, 0);
      rd_mask[i] = read_signal;
    end
    check("lit_idle_reads", int'(rd_mask), 16'h8888);
    check("lit_idle_flush", int'(flush), 1);
    check("lit_idle_occ", int'(occupancy), 0);

    // 2: three writes from phase 0
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); check("lit_occ_1", int'(occupancy), 1);
    step(1, 0, 0, 0, 0); check("lit_occ_2", int'(occupancy), 2);
    step(1, 0, 0, 0, 0); check("lit_occ_3", int'(occupancy), 3);
    check("lit_read_c19", int'(read_signal), 1);
    step(0, 0, 0, 0, 0); check("lit_occ_2b", int'(occupancy), 2);
    repeat (4) step(0, 0, 0, 0, 0);
    check("lit_occ_1b", int'(occupancy), 1);

    // 3: flush at phase 1 with occupancy 5
    repeat (5) step(1, 0, 0, 0, 0);
    check("lit_occ_5", int'(occupancy), 5);
    step(0, 1, 0, 0, 0);
    check("lit_flush_first", int'(flush), 0);
    check("lit_flush_busy", int'(busy), 1);
    check("lit_flush_occ", int'(occupancy), 0);
    step(0, 0, 0, 0, 0);
    check("lit_flush_noread", int'(read_signal), 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); check("lit_flush_last", int'(flush), 0);
    step(0, 0, 0, 0, 0); check("lit_flush_done", int'(flush), 1);
    step(0, 0, 0, 0, 0); check("lit_read_align", int'(read_signal), 1);

    // 4: synch lengths 3 and 0
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    cnt_a = int'(synch);
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 0, 0, 0);
      cnt_a += int'(synch);
    end
    check("lit_synch3_len", cnt_a, 11);
    step(0, 0, 1, 0, 0);
    cnt_a = int'(synch);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      cnt_a += int'(synch);
    end
    check("lit_synch0_len", cnt_a, 3);

    // 5: saturation and sticky overflow
    repeat (30) step(1, 0, 0, 0, 0);
    check("lit_sat_occ", int'(occupancy), 16);
    check("lit_sat_ovf", int'(overflow), 1);
    check("lit_sat_nf", int'(near_full), 1);
    repeat (8) step(0, 0, 0, 0, 0);
    check("lit_ovf_sticky", int'(overflow), 1);
    step(0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0);
    check("lit_ovf_in_synch", int'(overflow), 1);

    // 6: abort synch with flush, then simultaneous requests
    step(0, 1, 0, 0, 0);
    check("lit_abort_synch", int'(synch), 0);
    check("lit_abort_flush", int'(flush), 0);
    check("lit_abort_ovf", int'(overflow), 0);
    repeat (8) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 0);
    cnt_a = (flush == 1'b0) ? 1 : 0;
    cnt_b = int'(synch);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      cnt_a += (flush == 1'b0) ? 1 : 0;
      cnt_b += int'(synch);
    end
    check("lit_both_flush", cnt_a, 4);
    check("lit_both_synch", cnt_b, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 3),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 999) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
